// File: rtl/fetch_pc_unit.sv
// Program counter owner and single-outstanding instruction fetcher with decode hand-off.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets raise misalign_trap instead of redirecting.
module fetch_pc_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr,
`endif
  output logic            flush
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            kill_q;
  logic            imem_req_q;
  logic [XLEN-1:0] imem_addr_q;
  logic            if_valid_q;
  logic [31:0]     if_instr_q;
  logic [XLEN-1:0] if_pc_q;
  logic            flush_q;

  logic [XLEN-1:0] sum_br;
  logic [XLEN-1:0] sum_jr;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] tgt_d;
  logic            redir;
  logic            take_d;
  logic [XLEN-1:0] pc_inc;

`ifdef MISALIGN_TRAP_EN
  logic            misal_d;
  logic            misalign_trap_q;
  logic [XLEN-1:0] misalign_addr_q;
`endif

  always_comb begin
    sum_br  = ex_pc + imm;
    sum_jr  = rs1 + imm;
    tgt_raw = jalr ? (sum_jr & ~XLEN'(1)) : sum_br;
    redir   = branch | jump | jalr;
    pc_inc  = pc_q + XLEN'(4);
`ifdef MISALIGN_TRAP_EN
    misal_d = redir && (tgt_raw[1:0] != 2'b00);
    take_d  = redir && !misal_d;
    tgt_d   = tgt_raw;
`else
    take_d  = redir;
    tgt_d   = tgt_raw & ~XLEN'(3);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      flush_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap_q <= 1'b0;
      misalign_addr_q <= '0;
`endif
    end else begin
      flush_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap_q <= misal_d;
      if (misal_d) misalign_addr_q <= tgt_raw;
`endif
      if (take_d) begin
        pc_q       <= tgt_d;
        flush_q    <= 1'b1;
        if_valid_q <= 1'b0;
        // A granted-but-unanswered request must have its response discarded; an
        // ungranted one can simply be retargeted.
        if ((state_q == S_REQ && imem_gnt) || (state_q == S_WAIT && !imem_rvalid)) begin
          state_q    <= S_WAIT;
          kill_q     <= 1'b1;
          imem_req_q <= 1'b0;
        end else begin
          state_q     <= S_REQ;
          kill_q      <= 1'b0;
          imem_req_q  <= 1'b1;
          imem_addr_q <= tgt_d;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
          end
          S_REQ: begin
            if (imem_gnt) begin
              state_q    <= S_WAIT;
              imem_req_q <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (kill_q) begin
                kill_q      <= 1'b0;
                state_q     <= S_REQ;
                imem_req_q  <= 1'b1;
                imem_addr_q <= pc_q;
              end else begin
                if_instr_q <= imem_rdata;
                if_pc_q    <= pc_q;
                pc_q       <= pc_inc;
                if_valid_q <= 1'b1;
                state_q    <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (id_ready && !stall) begin
              if_valid_q  <= 1'b0;
              state_q     <= S_REQ;
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc_q;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign flush     = flush_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_trap = misalign_trap_q;
  assign misalign_addr = misalign_addr_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: redirect vector table, fetch scoreboard, directed corner sequences.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch = 1'b0, jump = 1'b0, jalr = 1'b0;
  logic [31:0] ex_pc = '0, imm = '0, rs1 = '0;
  logic        stall = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req, if_valid, flush;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic        imem_req2, if_valid2, flush2;
  logic [31:0] imem_addr2, if_instr2, if_pc2;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap, misalign_trap2;
  logic [31:0] misalign_addr, misalign_addr2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        br, jp, jr;
    logic [31:0] expc, im, r1;
    logic [31:0] exp_addr;
  } vec_t;

  fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .branch(branch), .jump(jump), .jalr(jalr),
    .ex_pc(ex_pc), .imm(imm), .rs1(rs1), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
`ifdef MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap), .misalign_addr(misalign_addr),
`endif
    .flush(flush)
  );

  fetch_pc_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .branch(branch), .jump(jump), .jalr(jalr),
    .ex_pc(ex_pc), .imm(imm), .rs1(rs1), .stall(stall),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .id_ready(id_ready),
`ifdef MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap2), .misalign_addr(misalign_addr2),
`endif
    .flush(flush2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every rising if_valid must match the oldest accepted response.
  logic prev_v = 1'b0;
  always @(posedge clk) begin
    #1;
    if (if_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL sb_unexpected: if_valid rose with if_pc 0x%08h, no response pending", if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", if_instr, e.instr);
        chk("sb_pc", if_pc, e.pc);
      end
    end
    prev_v = if_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] pc_e;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0,         32'h0000_00F0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0020, 32'h0,         32'h0000_1020};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0010, 32'h0000_0300, 32'h0000_0310};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0800, 32'h0000_0004, 32'h0000_0040, 32'h0000_0044};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         32'h0000_0010};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0003, 32'h0000_0201, 32'h0000_0204};

    // Reset values
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
    rst = 1'b0;

    // First fetch
    tick();
    chk("f1_req", {31'b0, imem_req}, 32'h1);
    chk("f1_addr", imem_addr, 32'h0);
    chk("f1_addr2", imem_addr2, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    tick();
    chk("f1_req_drop", {31'b0, imem_req}, 32'h0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    exp_q.push_back('{32'h0000_0013, 32'h0});
    tick();
    chk("f1_valid", {31'b0, if_valid}, 32'h1);
    imem_rvalid = 1'b0; id_ready = 1'b1;
    tick();
    chk("f2_addr", imem_addr, 32'h4);
    chk("f2_addr2_wrap", imem_addr2, 32'h0);
    chk("f2_req", {31'b0, imem_req}, 32'h1);
    chk("f2_valid_drop", {31'b0, if_valid}, 32'h0);

    // Request held while not granted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", {31'b0, imem_req}, 32'h1);
      chk("hold_addr", imem_addr, 32'h4);
    end

    // Redirect table, applied while sitting in S_REQ without grant
    for (int i = 0; i < 6; i++) begin
      branch = vecs[i].br; jump = vecs[i].jp; jalr = vecs[i].jr;
      ex_pc = vecs[i].expc; imm = vecs[i].im; rs1 = vecs[i].r1;
      tick();
      branch = 1'b0; jump = 1'b0; jalr = 1'b0;
      chk("vec_addr", imem_addr, vecs[i].exp_addr);
      chk("vec_flush", {31'b0, flush}, 32'h1);
      chk("vec_req", {31'b0, imem_req}, 32'h1);
      tick();
      chk("vec_flush_1cyc", {31'b0, flush}, 32'h0);
      chk("vec_addr_hold", imem_addr, vecs[i].exp_addr);
    end

    // Branch while in S_WAIT: in-flight response discarded
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    branch = 1'b1; ex_pc = 32'h0000_0100; imm = 32'hFFFF_FFF0;
    tick();
    branch = 1'b0;
    chk("wait_br_flush", {31'b0, flush}, 32'h1);
    chk("wait_br_req", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("wait_br_flush_off", {31'b0, flush}, 32'h0);
    chk("wait_br_addr", imem_addr, 32'h0000_00F0);
    chk("wait_br_req2", {31'b0, imem_req}, 32'h1);
    chk("wait_br_novalid", {31'b0, if_valid}, 32'h0);

    // jalr+branch with misaligned raw target 0x202
    jalr = 1'b1; branch = 1'b1; rs1 = 32'h0000_0203; imm = 32'h0; ex_pc = 32'h0000_0400;
    tick();
    jalr = 1'b0; branch = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk("mis_trap", {31'b0, misalign_trap}, 32'h1);
    chk("mis_addr", misalign_addr, 32'h0000_0202);
    chk("mis_noflush", {31'b0, flush}, 32'h0);
    chk("mis_pc_keep", imem_addr, 32'h0000_00F0);
    tick();
    chk("mis_trap_1cyc", {31'b0, misalign_trap}, 32'h0);
    pc_e = 32'h0000_00F0;
`else
    chk("jalr_align_addr", imem_addr, 32'h0000_0200);
    chk("jalr_align_flush", {31'b0, flush}, 32'h1);
    pc_e = 32'h0000_0200;
`endif

    // Stall holds the hand-off for 4 cycles
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093; stall = 1'b1;
    exp_q.push_back('{32'h00A0_0093, pc_e});
    tick();
    imem_rvalid = 1'b0;
    chk("stall_valid0", {31'b0, if_valid}, 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("stall_valid", {31'b0, if_valid}, 32'h1);
      chk("stall_noreq", {31'b0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("stall_release_valid", {31'b0, if_valid}, 32'h0);
    chk("stall_release_req", {31'b0, imem_req}, 32'h1);
    chk("stall_release_addr", imem_addr, pc_e + 32'h4);

    // Asynchronous reset in S_WAIT, late response ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_instr", if_instr, 32'h0);
    chk("arst_flush", {31'b0, flush}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    rst = 1'b0;
    tick();
    imem_rvalid = 1'b0;
    chk("arst_after_req", {31'b0, imem_req}, 32'h1);
    chk("arst_after_addr", imem_addr, 32'h0);
    chk("arst_after_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_after_addr2", imem_addr2, 32'hFFFF_FFFC);
    tick();
    chk("arst_late_ignored", {31'b0, if_valid}, 32'h0);

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
